// File: rtl/eco32f_regfile.sv
// eco32f_regfile: 32 x 32-bit register file with two registered read ports
// and one write port. After reset a 32-cycle sweep clears every entry while
// rf_busy is high; normal operation starts once the sweep is done.
// Optional feature: define ECO32F_RF_BYPASS_EN to forward same-edge writes
// to the read ports and to refresh held outputs during decode stalls.
module eco32f_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        rf_re,
  input  logic [4:0]  rf_a_addr,
  input  logic [4:0]  rf_b_addr,
  input  logic        wb_rf_r_we,
  input  logic [4:0]  wb_rf_r_addr,
  input  logic [31:0] wb_rf_r,
  output logic [31:0] rf_a,
  output logic [31:0] rf_b,
  output logic        rf_busy
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [4:0]  held_a_q;
  logic [4:0]  held_b_q;
  logic [31:0] rf_a_q;
  logic [31:0] rf_b_q;
  logic        busy_q;
  logic [31:0] mem_q [32];

  logic        wr_en;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic [31:0] rf_a_d;
  logic [31:0] rf_b_d;

  // A writeback only lands in RUN and never in entry 0.
  assign wr_en = (state_q == RUN) && wb_rf_r_we && (wb_rf_r_addr != 5'd0);

  // Array read with optional same-edge forwarding; index 0 always reads zero.
  always_comb begin
    rd_a = mem_q[rf_a_addr];
    rd_b = mem_q[rf_b_addr];
`ifdef ECO32F_RF_BYPASS_EN
    if (wr_en && (wb_rf_r_addr == rf_a_addr)) rd_a = wb_rf_r;
    if (wr_en && (wb_rf_r_addr == rf_b_addr)) rd_b = wb_rf_r;
`endif
    if (rf_a_addr == 5'd0) rd_a = '0;
    if (rf_b_addr == 5'd0) rd_b = '0;
  end

  // Next output value: capture on rf_re, otherwise hold (optionally refreshed
  // when the held register is rewritten); forced to zero during the sweep.
  always_comb begin
    rf_a_d = rf_a_q;
    rf_b_d = rf_b_q;
    if (state_q == CLEAR) begin
      rf_a_d = '0;
      rf_b_d = '0;
    end else if (rf_re) begin
      rf_a_d = rd_a;
      rf_b_d = rd_b;
    end else begin
`ifdef ECO32F_RF_BYPASS_EN
      if (wr_en && (wb_rf_r_addr == held_a_q)) rf_a_d = wb_rf_r;
      if (wr_en && (wb_rf_r_addr == held_b_q)) rf_b_d = wb_rf_r;
`endif
    end
  end

  // Control FSM: clear sweep, then run; also holds read addresses and outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= CLEAR;
      cnt_q    <= 5'd0;
      busy_q   <= 1'b1;
      held_a_q <= 5'd0;
      held_b_q <= 5'd0;
      rf_a_q   <= '0;
      rf_b_q   <= '0;
    end else begin
      rf_a_q <= rf_a_d;
      rf_b_q <= rf_b_d;
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (rf_re) begin
            held_a_q <= rf_a_addr;
            held_b_q <= rf_b_addr;
          end
        end
      endcase
    end
  end

  // Storage: sweep writes zero during CLEAR, writeback writes during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
        mem_q[wb_rf_r_addr] <= wb_rf_r;
      end
    end
  end

  assign rf_a    = rf_a_q;
  assign rf_b    = rf_b_q;
  assign rf_busy = busy_q;

endmodule

// File: tb/tb_eco32f_regfile.sv
// Scoreboard bench for eco32f_regfile: stimulus queues expected outputs
// tagged with the cycle they must appear in; a monitor compares them.
module tb_eco32f_regfile;

`ifdef ECO32F_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_re;
  logic [4:0]  rf_a_addr;
  logic [4:0]  rf_b_addr;
  logic        wb_rf_r_we;
  logic [4:0]  wb_rf_r_addr;
  logic [31:0] wb_rf_r;
  logic [31:0] rf_a;
  logic [31:0] rf_b;
  logic        rf_busy;

  eco32f_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .rf_re        (rf_re),
    .rf_a_addr    (rf_a_addr),
    .rf_b_addr    (rf_b_addr),
    .wb_rf_r_we   (wb_rf_r_we),
    .wb_rf_r_addr (wb_rf_r_addr),
    .wb_rf_r      (wb_rf_r),
    .rf_a         (rf_a),
    .rf_b         (rf_b),
    .rf_busy      (rf_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      item_t it;
      logic [31:0] act;
      it = q.pop_front();
      case (it.sel)
        0:       act = rf_a;
        1:       act = rf_b;
        default: act = {31'd0, rf_busy};
      endcase
      n_checks++;
      if (it.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", it.name, it.cyc, cyc);
      end else if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", it.name, act, it.exp, cyc);
      end
    end
  end

  // Expectation for the outputs right after the upcoming edge.
  task automatic expect_nx(input int sel, input logic [31:0] v, input string name);
    item_t it;
    it.cyc = cyc + 1;
    it.sel = sel;
    it.exp = v;
    it.name = name;
    q.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re, input logic [4:0] a, input logic [4:0] b,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    rf_re = re; rf_a_addr = a; rf_b_addr = b;
    wb_rf_r_we = we; wb_rf_r_addr = wa; wb_rf_r = wd;
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    drive(1'b0, 5'd0, 5'd0, 1'b1, wa, wd);
    tick();
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b,
                    input logic [31:0] ea, input logic [31:0] eb, input string name);
    drive(1'b1, a, b, 1'b0, 5'd0, 32'd0);
    expect_nx(0, ea, {name, "_a"});
    expect_nx(1, eb, {name, "_b"});
    tick();
  endtask

  // Hold rst=1 for n edges, expecting busy to stay high, then one more edge
  // on which the sweep must finish.
  task automatic sweep(input int n, input string name);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      expect_nx(2, 32'd1, {name, "_busy_hi"});
      tick();
    end
    expect_nx(2, 32'd0, {name, "_busy_lo"});
    tick();
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 5'd4, 5'd4, 1'b1, 5'd4, 32'h1234_5678);
    // reset edge: busy high, outputs zero
    expect_nx(2, 32'd1, "rst_busy");
    expect_nx(0, 32'd0, "rst_rf_a");
    expect_nx(1, 32'd0, "rst_rf_b");
    tick();
    // sweep with writes/reads attempted; both ignored
    rst = 1'b1;
    for (int i = 0; i < 31; i++) begin
      expect_nx(2, 32'd1, "clear_busy");
      if (i == 15) expect_nx(0, 32'd0, "clear_rf_a");
      tick();
    end
    expect_nx(2, 32'd0, "run_busy");
    tick();
    // every index reads zero
    for (int i = 0; i < 32; i++) begin
      logic [4:0] ia;
      logic [4:0] ib;
      ia = 5'(i);
      ib = 5'(31 - i);
      rd(ia, ib, 32'd0, 32'd0, "zero_rd");
    end
    // basic write then read
    wr(5'd5, 32'hDEAD_BEEF);
    rd(5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0, "r5");
    // r0 discards writes
    wr(5'd0, 32'hFFFF_FFFF);
    rd(5'd0, 5'd0, 32'd0, 32'd0, "r0");
    // both ports same index
    rd(5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "same_idx");
    // same-edge collision
    wr(5'd7, 32'h1111_1111);
    drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h2222_2222);
    expect_nx(0, BYP ? 32'h2222_2222 : 32'h1111_1111, "coll_a");
    expect_nx(1, BYP ? 32'h2222_2222 : 32'h1111_1111, "coll_b");
    tick();
    rd(5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222, "after_coll");
    // held output refresh during stall
    wr(5'd9, 32'h0000_0009);
    rd(5'd9, 5'd2, 32'h0000_0009, 32'd0, "r9");
    drive(1'b0, 5'd1, 5'd1, 1'b1, 5'd9, 32'hA5A5_A5A5);
    expect_nx(0, BYP ? 32'hA5A5_A5A5 : 32'h0000_0009, "held_refresh_a");
    expect_nx(1, 32'd0, "held_refresh_b");
    tick();
    drive(1'b0, 5'd10, 5'd10, 1'b1, 5'd10, 32'h0000_0077);
    expect_nx(0, BYP ? 32'hA5A5_A5A5 : 32'h0000_0009, "other_wr_a");
    expect_nx(1, 32'd0, "other_wr_b");
    tick();
    rd(5'd9, 5'd10, 32'hA5A5_A5A5, 32'h0000_0077, "r9_r10");
    // reset mid-sweep restarts the clear
    wr(5'd3, 32'h0000_0003);
    rd(5'd3, 5'd5, 32'h0000_0003, 32'hDEAD_BEEF, "r3");
    rst = 1'b0;
    expect_nx(2, 32'd1, "rst2_busy");
    expect_nx(0, 32'd0, "rst2_rf_a");
    expect_nx(1, 32'd0, "rst2_rf_b");
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_nx(2, 32'd1, "sweep2_busy");
      tick();
    end
    rst = 1'b0;
    expect_nx(2, 32'd1, "rst3_busy");
    tick();
    sweep(31, "sweep3");
    rd(5'd3, 5'd5, 32'd0, 32'd0, "r3_cleared");
    // drain the scoreboard within a bounded number of cycles
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
